cpu_mem_bridge: RTL
===================

// Module: cpu_mem_bridge
// PURPOSE
// Memory-side neighbour of the CPU core: consumes its data-memory port (write flag/addr/data, read addr) and returns read data.
// Decodes the address space into on-chip data RAM (below IO_BASE) and a memory-mapped IO window (IO_BASE and above).
// IO writes are posted into a FIFO and drained to a slow peripheral bus over a req/ack handshake, so the core never stalls.
// A status register at IO_BASE reports FIFO state and a sticky overflow flag.
// PARAMETERS
// WORD_WIDTH   16      data and address width, from the shared header
// RAM_AW       8       data RAM address bits; RAM holds 2**RAM_AW words
// IO_BASE      16'hFF00 first IO address; STATUS register lives here
// FIFO_DEPTH   4       posted-write FIFO entries (power of 2)
// PORTS
// gclk          in   1    system clock, all state on rising edge
// PowerOn       in   1    reset, synchronous, active-low (0 = held in reset)
// MemWriteFlag  in   1    core write strobe, one write per asserted cycle
// MemWriteAddr  in   16   core write address
// MemWriteData  in   16   core write data
// MemReadAddr   in   16   core read address, sampled every cycle
// MemReadData   out  16   read data, valid the cycle after MemReadAddr
// ExtReq        out  1    peripheral request, held until ExtAck
// ExtAddr       out  16   peripheral address, stable while ExtReq=1
// ExtData       out  16   peripheral write data, stable while ExtReq=1
// ExtAck        in   1    peripheral accept, single-cycle pulse
// BEHAVIOUR
// Reset (PowerOn=0 at an edge): FIFO emptied, overflow=0, FSM->IDLE, ExtReq=0, ExtAddr/ExtData=0, MemReadData=0. RAM contents not cleared.
// Reset mid-handshake: ExtReq drops the next edge and the pending entry is discarded. Peripheral must tolerate abandoned requests.
// Decode: addr < IO_BASE -> RAM, index = addr[RAM_AW-1:0] (upper bits ignored, aliasing). addr >= IO_BASE -> IO.
// RAM write: committed at the edge where MemWriteFlag=1.
// RAM read: registered, latency exactly 1. On a same-cycle read and write to the same word, the read returns OLD data (read-first).
// IO read at IO_BASE returns STATUS, registered with latency 1:
//   [15] overflow, [14] full, [13] empty, [12:3] zero, [2:0] count (0..FIFO_DEPTH).
// IO read at any other IO address returns 16'h0000.
// IO write to IO_BASE: not queued; clears overflow. Clear has priority over a same-cycle overflow set.
// IO write to any other IO address: pushes {addr,data}.
//   Push accepted if count<DEPTH, or if a pop occurs in the same cycle.
//   Otherwise the write is dropped and overflow is set (sticky).
// Simultaneous push and pop: count unchanged, and both pointers advance.
// Pointers: wrap modulo FIFO_DEPTH. Count is tracked separately to tell full from empty.
// Drain FSM (3 states):
//   IDLE: if !empty, load head into ExtAddr/ExtData, ExtReq=1 -> REQ.
//   REQ: hold ExtReq/ExtAddr/ExtData. On ExtAck=1: pop head, ExtReq=0 -> GAP.
//   GAP: one mandatory idle cycle (ExtReq=0) -> IDLE.
// Best-case drain rate: 1 entry per 3 cycles with immediate ack.
// ExtAck while ExtReq=0 is ignored.
// Ordering: IO writes reach the peripheral in program order. RAM writes bypass the FIFO; no ordering between RAM and IO is guaranteed.
// STRUCTURE
// Shared header (CoreHeader.v): WORD_WIDTH, IO_BASE, STATUS bit positions, drain FSM state encodings.
// Sub-module post_fifo: parameterised DEPTH x 32-bit FIFO with push/pop/full/empty/count and push-with-pop-when-full semantics.
// Top level holds the decode, the RAM array with registered read, the status/overflow logic, the drain FSM and the read mux register.
// TESTING
// 1. Reset: hold PowerOn=0 two cycles -> ExtReq=0, MemReadData=0. Read IO_BASE -> 16'h2000 (empty, count 0).
// 2. RAM: write 16'hBEEF @16'h0012, then read @16'h0012 -> BEEF one cycle later. Read and write 16'h1234 @0012 in the same cycle -> BEEF, then next read -> 1234.
// 3. Posted write: write 16'hA5A5 @16'hFF10, ExtAck returned 2 cycles after ExtReq -> ExtReq rises the next cycle with ExtAddr=FF10, ExtData=A5A5, drops after ack. Status returns to empty.
// 4. Overflow: hold ExtAck=0, issue 5 IO writes -> status 16'hC004 (overflow, full, count 4). Write @IO_BASE -> 16'h4004. Ack x4 -> the first 4 entries arrive in order.
// 5. Full with push+pop: FIFO full, ExtAck pulse coincides with a push -> push accepted, count stays 4, overflow stays 0.
// 6. Reset mid-REQ: PowerOn=0 while ExtReq=1 -> ExtReq=0 next edge. Status after release -> 16'h2000. Any later ExtAck is ignored.

Source files
------------

// File: rtl/cpu_mem_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_mem_bridge_pkg                                               |
// | Brief   : Shared word width, IO map, status bit layout and drain states.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_mem_bridge_pkg;

    localparam int WORD_WIDTH = 16;
    localparam logic [WORD_WIDTH-1:0] IO_BASE = 16'hFF00;

    localparam int ST_OVERFLOW = 15;
    localparam int ST_FULL     = 14;
    localparam int ST_EMPTY    = 13;

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_REQ  = 2'd1,
        DRAIN_GAP  = 2'd2
    } drain_state_t;

    function automatic logic is_io(input logic [WORD_WIDTH-1:0] addr);
        return addr >= IO_BASE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mem_bridge_post_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_mem_bridge_post_fifo                                         |
// | Brief   : Posted-write FIFO; a push into a full FIFO is accepted when a    |
// |           pop happens in the same cycle.                                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cpu_mem_bridge_post_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign w_pop_ok  = pop_i && !empty_o;
    assign w_push_ok = push_i && (!full_o || w_pop_ok);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/cpu_mem_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_mem_bridge                                                   |
// | Brief   : Core data-memory port to on-chip RAM plus posted IO writes       |
// |           drained to a req/ack peripheral bus.                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cpu_mem_bridge
    import cpu_mem_bridge_pkg::*;
#(
    parameter int RAM_AW     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  gclk,
    input  logic                  PowerOn,
    input  logic                  MemWriteFlag,
    input  logic [WORD_WIDTH-1:0] MemWriteAddr,
    input  logic [WORD_WIDTH-1:0] MemWriteData,
    input  logic [WORD_WIDTH-1:0] MemReadAddr,
    output logic [WORD_WIDTH-1:0] MemReadData,
    output logic                  ExtReq,
    output logic [WORD_WIDTH-1:0] ExtAddr,
    output logic [WORD_WIDTH-1:0] ExtData,
    input  logic                  ExtAck
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [WORD_WIDTH-1:0]   ram_q [2**RAM_AW];
    logic [WORD_WIDTH-1:0]   rdata_q;
    logic                    overflow_q;
    drain_state_t            state_q;
    logic                    ext_req_q;
    logic [WORD_WIDTH-1:0]   ext_addr_q;
    logic [WORD_WIDTH-1:0]   ext_data_q;

    logic                    w_wr_ram;
    logic                    w_wr_status;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_drop;
    logic [2*WORD_WIDTH-1:0] w_head;
    logic                    w_full;
    logic                    w_empty;
    logic [CNT_W-1:0]        w_count;
    logic [WORD_WIDTH-1:0]   w_status;
    logic [WORD_WIDTH-1:0]   w_rdata;

    assign w_wr_ram    = MemWriteFlag && !is_io(MemWriteAddr);
    assign w_wr_status = MemWriteFlag && (MemWriteAddr == IO_BASE);
    assign w_push      = MemWriteFlag && is_io(MemWriteAddr) && (MemWriteAddr != IO_BASE);
    assign w_pop       = (state_q == DRAIN_REQ) && ExtAck;
    assign w_drop      = w_push && w_full && !w_pop;

    cpu_mem_bridge_post_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*WORD_WIDTH)
    ) u_post_fifo (
        .clk_i       (gclk),
        .rst_ni      (PowerOn),
        .push_i      (w_push),
        .push_data_i ({MemWriteAddr, MemWriteData}),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    // RAM is deliberately not reset; non-blocking write gives read-first behaviour.
    always_ff @(posedge gclk) begin
        if (w_wr_ram) ram_q[MemWriteAddr[RAM_AW-1:0]] <= MemWriteData;
    end

    always_comb begin
        w_status              = '0;
        w_status[ST_OVERFLOW] = overflow_q;
        w_status[ST_FULL]     = w_full;
        w_status[ST_EMPTY]    = w_empty;
        w_status[CNT_W-1:0]   = w_count;
        w_rdata               = '0;
        if (!is_io(MemReadAddr))          w_rdata = ram_q[MemReadAddr[RAM_AW-1:0]];
        else if (MemReadAddr == IO_BASE)  w_rdata = w_status;
    end

    always_ff @(posedge gclk) begin
        if (!PowerOn) begin
            rdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rdata_q <= w_rdata;
            if (w_wr_status)  overflow_q <= 1'b0;
            else if (w_drop)  overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge gclk) begin
        if (!PowerOn) begin
            state_q    <= DRAIN_IDLE;
            ext_req_q  <= 1'b0;
            ext_addr_q <= '0;
            ext_data_q <= '0;
        end else begin
            case (state_q)
                DRAIN_IDLE: begin
                    if (!w_empty) begin
                        ext_addr_q <= w_head[2*WORD_WIDTH-1:WORD_WIDTH];
                        ext_data_q <= w_head[WORD_WIDTH-1:0];
                        ext_req_q  <= 1'b1;
                        state_q    <= DRAIN_REQ;
                    end
                end
                DRAIN_REQ: begin
                    if (ExtAck) begin
                        ext_req_q <= 1'b0;
                        state_q   <= DRAIN_GAP;
                    end
                end
                DRAIN_GAP: state_q <= DRAIN_IDLE;
                default: begin
                    ext_req_q <= 1'b0;
                    state_q   <= DRAIN_IDLE;
                end
            endcase
        end
    end

    assign MemReadData = rdata_q;
    assign ExtReq      = ext_req_q;
    assign ExtAddr     = ext_addr_q;
    assign ExtData     = ext_data_q;

endmodule
`default_nettype wire
